// File: rtl/disp_min_reduce.sv
// disp_min_reduce
//   Two-stage arg-min reducer for disparity cost volumes. Stage 1 picks, per
//   group, the cheapest of RADIX incoming entries. Stage 2 folds BEATS
//   consecutive stage-1 results into one minimum and publishes it.
//   Each published entry records the winning cost, the beat and radix
//   position it came from, and the suffix carried in from the previous stage.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   clken    : global clock enable; nothing advances while low
//   valid    : cost_in carries a beat this cycle
//   flush    : synchronous restart of beat folding; has priority over valid
//   cost_in  : NUM_GROUPS*RADIX entries of IW bits, {cost, suffix} each
//   cost_out : NUM_GROUPS results of OW bits, {cost, beat_idx, radix_idx, suffix}
//   en       : cost_out holds a new result this cycle
module disp_min_reduce #(
  parameter int NUM_GROUPS = 64,
  parameter int RADIX      = 4,
  parameter int COST_W     = 5,
  parameter int SUF_W      = 0,
  parameter int BEATS      = 1,
  localparam int RW        = $clog2(RADIX),
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 0,
  localparam int IW        = COST_W + SUF_W,
  localparam int OW        = COST_W + BW + RW + SUF_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clken,
  input  logic                             valid,
  input  logic                             flush,
  input  logic [NUM_GROUPS*RADIX*IW-1:0]   cost_in,
  output logic [NUM_GROUPS*OW-1:0]         cost_out,
  output logic                             en
);

  // Beat counter is kept at least one bit wide so it can always be declared;
  // with a single beat it never leaves zero.
  localparam int BWX = (BW > 0) ? BW : 1;
  localparam logic [BWX-1:0] LAST_BEAT = BWX'(BEATS - 1);

  logic           s1_valid;
  logic [BWX-1:0] beat_cnt;
  logic           last_beat;

  assign last_beat = (beat_cnt == LAST_BEAT);

  // Shared control: stage-1 valid, beat counter and result strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      beat_cnt <= '0;
      en       <= 1'b0;
    end else if (clken) begin
      if (flush) begin
        s1_valid <= 1'b0;
        beat_cnt <= '0;
        en       <= 1'b0;
      end else begin
        s1_valid <= valid;
        en       <= s1_valid && last_beat;
        if (s1_valid) begin
          beat_cnt <= last_beat ? '0 : beat_cnt + BWX'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    logic [IW-1:0]  min_ent;
    logic [RW-1:0]  min_ridx;
    logic [IW-1:0]  s1_ent;
    logic [RW-1:0]  s1_ridx;
    logic [IW-1:0]  acc_ent;
    logic [RW-1:0]  acc_ridx;
    logic [BWX-1:0] acc_beat;
    logic           take_new;
    logic [IW-1:0]  fold_ent;
    logic [RW-1:0]  fold_ridx;
    logic [BWX-1:0] fold_beat;
    logic [OW-1:0]  fold_pack;
    logic [OW-1:0]  out_q;

    // Linear scan with a strict compare so equal costs keep the lowest index.
    always_comb begin
      min_ent  = cost_in[(g*RADIX)*IW +: IW];
      min_ridx = '0;
      for (int r = 1; r < RADIX; r++) begin
        if (cost_in[(g*RADIX+r)*IW+SUF_W +: COST_W] < min_ent[IW-1 -: COST_W]) begin
          min_ent  = cost_in[(g*RADIX+r)*IW +: IW];
          min_ridx = RW'(r);
        end
      end
    end

    // The first beat of a fold always loads; later beats replace only on a
    // strictly lower cost so ties stay with the earlier beat.
    always_comb begin
      take_new  = (beat_cnt == '0) ||
                  (s1_ent[IW-1 -: COST_W] < acc_ent[IW-1 -: COST_W]);
      fold_ent  = take_new ? s1_ent   : acc_ent;
      fold_ridx = take_new ? s1_ridx  : acc_ridx;
      fold_beat = take_new ? beat_cnt : acc_beat;
    end

    // Pack with shifts so zero-width beat and suffix fields drop out cleanly.
    always_comb begin
      fold_pack = OW'(fold_ent[IW-1 -: COST_W]) << (BW + RW + SUF_W);
      fold_pack = fold_pack | (OW'(fold_beat) << (RW + SUF_W));
      fold_pack = fold_pack | (OW'(fold_ridx) << SUF_W);
      fold_pack = fold_pack | (OW'(fold_ent) & ((OW'(1) << SUF_W) - OW'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_ent   <= '0;
        s1_ridx  <= '0;
        acc_ent  <= '0;
        acc_ridx <= '0;
        acc_beat <= '0;
        out_q    <= '0;
      end else if (clken) begin
        if (valid) begin
          s1_ent  <= min_ent;
          s1_ridx <= min_ridx;
        end
        if (!flush && s1_valid) begin
          acc_ent  <= fold_ent;
          acc_ridx <= fold_ridx;
          acc_beat <= fold_beat;
          if (last_beat) begin
            out_q <= fold_pack;
          end
        end
      end
    end

    assign cost_out[g*OW +: OW] = out_q;
  end

endmodule

// File: tb/tb_disp_min_reduce.sv
// Bench for disp_min_reduce: three instances with different shapes
// (A: 64 groups radix 4 single beat; B: radix 4, 4 beats; C: radix 2,
// 2-bit suffix, 3 beats), a hand-derived vector table, hand-written reset
// sequences and randomized stimulus against a behavioural fold model.
module tb_disp_min_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   ce, vl, fl;
  logic [1279:0] cin_a;
  logic [39:0]   cin_b;
  logic [27:0]   cin_c;
  logic [447:0]  out_a;
  logic [17:0]   out_b;
  logic [19:0]   out_c;
  logic          en_a, en_b, en_c;

  disp_min_reduce #(.NUM_GROUPS(64), .RADIX(4), .COST_W(5), .SUF_W(0), .BEATS(1)) u_a (
    .clk(clk), .rst(rst), .clken(ce[0]), .valid(vl[0]), .flush(fl[0]),
    .cost_in(cin_a), .cost_out(out_a), .en(en_a));
  disp_min_reduce #(.NUM_GROUPS(2), .RADIX(4), .COST_W(5), .SUF_W(0), .BEATS(4)) u_b (
    .clk(clk), .rst(rst), .clken(ce[1]), .valid(vl[1]), .flush(fl[1]),
    .cost_in(cin_b), .cost_out(out_b), .en(en_b));
  disp_min_reduce #(.NUM_GROUPS(2), .RADIX(2), .COST_W(5), .SUF_W(2), .BEATS(3)) u_c (
    .clk(clk), .rst(rst), .clken(ce[2]), .valid(vl[2]), .flush(fl[2]),
    .cost_in(cin_c), .cost_out(out_c), .en(en_c));

  int ng_p [3] = '{64, 2, 2};
  int rad_p[3] = '{4, 4, 2};
  int sw_p [3] = '{0, 0, 2};
  int bt_p [3] = '{1, 4, 3};
  int bw_p [3] = '{0, 2, 2};
  int rw_p [3] = '{2, 2, 1};

  int in_e [3][64][8];

  // Reference model: one-cycle input delay, then a list of collected beats
  // which is reduced by a plain scan once BEATS of them are present.
  bit d1_v [3];
  int d1_e [3][64][8];
  int blist[3][16][64][8];
  int bcnt [3];
  bit exp_en [3];
  int exp_out[3][64];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    int inst;
    bit v;
    bit f;
    bit c;
    int e0;
    int e1;
    int e2;
    int e3;
    bit xen;
    int xg0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int inst, bit v, bit f, bit c,
                              int e0, int e1, int e2, int e3, bit xen, int xg0);
    vec_t t;
    t.inst = inst; t.v = v; t.f = f; t.c = c;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    t.xen = xen; t.xg0 = xg0;
    return t;
  endfunction

  task automatic pack_inputs();
    for (int g = 0; g < 64; g++)
      for (int r = 0; r < 4; r++) cin_a[(g*4+r)*5 +: 5] = in_e[0][g][r][4:0];
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < 4; r++) cin_b[(g*4+r)*5 +: 5] = in_e[1][g][r][4:0];
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < 2; r++) cin_c[(g*2+r)*7 +: 7] = in_e[2][g][r][6:0];
  endtask

  function automatic int get_out(int i, int g);
    case (i)
      0:       return int'(out_a[g*7 +: 7]);
      1:       return int'(out_b[g*9 +: 9]);
      default: return int'(out_c[g*10 +: 10]);
    endcase
  endfunction

  function automatic bit get_en(int i);
    case (i)
      0:       return en_a;
      1:       return en_b;
      default: return en_c;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      d1_v[i] = 0; bcnt[i] = 0; exp_en[i] = 0;
      for (int g = 0; g < 64; g++) exp_out[i][g] = 0;
    end
  endtask

  task automatic model_fold(int i);
    for (int g = 0; g < ng_p[i]; g++) begin
      int best = 1 << 30;
      int bb = 0, br = 0, bs = 0;
      for (int b = 0; b < bt_p[i]; b++)
        for (int r = 0; r < rad_p[i]; r++) begin
          int e = blist[i][b][g][r];
          int c = e >> sw_p[i];
          if (c < best) begin
            best = c; bb = b; br = r; bs = e & ((1 << sw_p[i]) - 1);
          end
        end
      exp_out[i][g] = (((((best << bw_p[i]) | bb) << rw_p[i]) | br) << sw_p[i]) | bs;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (ce[i]) begin
        if (fl[i]) begin
          bcnt[i] = 0; d1_v[i] = 0; exp_en[i] = 0;
        end else begin
          exp_en[i] = 0;
          if (d1_v[i]) begin
            for (int g = 0; g < 64; g++)
              for (int r = 0; r < 8; r++) blist[i][bcnt[i]][g][r] = d1_e[i][g][r];
            bcnt[i]++;
            if (bcnt[i] == bt_p[i]) begin
              model_fold(i);
              exp_en[i] = 1;
              bcnt[i] = 0;
            end
          end
          d1_v[i] = vl[i];
          if (vl[i])
            for (int g = 0; g < 64; g++)
              for (int r = 0; r < 8; r++) d1_e[i][g][r] = in_e[i][g][r];
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      int bad = -1;
      n_tests++;
      if (get_en(i) != exp_en[i]) begin
        n_fail++;
        $display("FAIL %s inst%0d en: got %0d expected %0d", tag, i, get_en(i), exp_en[i]);
      end
      n_tests++;
      for (int g = 0; g < ng_p[i]; g++)
        if (bad < 0 && get_out(i, g) != exp_out[i][g]) bad = g;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s inst%0d out group %0d: got %0d expected %0d",
                 tag, i, bad, get_out(i, bad), exp_out[i][bad]);
      end
    end
  endtask

  task automatic cycle(input string tag);
    pack_inputs();
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    ce = 3'b111; vl = 3'b000; fl = 3'b000;
  endtask

  task automatic check_val(input string tag, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++)
      for (int g = 0; g < 64; g++)
        for (int r = 0; r < 8; r++) in_e[i][g][r] = 31 << sw_p[i];
    pack_inputs();
    model_reset();
    #2;
    check_all("reset");
    #1 rst = 1'b1;

    // inst, v, f, clken, e0..e3 (group 0), expected en, expected group 0
    tbl.push_back(mk(0,1,0,1, 9,3,7,3, 0,0));
    tbl.push_back(mk(0,0,0,1, 9,3,7,3, 1,13));
    tbl.push_back(mk(0,0,0,1, 9,3,7,3, 0,13));
    tbl.push_back(mk(0,1,0,1, 8,8,2,6, 0,13));
    tbl.push_back(mk(0,0,0,0, 8,8,2,6, 0,13));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 0,13));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,13));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 1,10));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 0,10));
    tbl.push_back(mk(0,1,0,1, 5,4,4,6, 0,10));
    tbl.push_back(mk(0,1,0,1, 1,2,3,0, 1,17));
    tbl.push_back(mk(0,0,0,1, 1,2,3,0, 1,3));
    tbl.push_back(mk(0,0,0,1, 1,2,3,0, 0,3));
    tbl.push_back(mk(1,1,0,1, 6,9,9,9, 0,0));
    tbl.push_back(mk(1,1,0,1, 9,9,2,9, 0,0));
    tbl.push_back(mk(1,1,0,1, 2,9,9,9, 0,0));
    tbl.push_back(mk(1,1,0,1, 9,5,9,9, 0,0));
    tbl.push_back(mk(1,0,0,1, 9,5,9,9, 1,38));
    tbl.push_back(mk(1,0,0,1, 9,5,9,9, 0,38));
    tbl.push_back(mk(1,1,0,1, 3,3,3,3, 0,38));
    tbl.push_back(mk(1,1,0,1, 0,0,0,0, 0,38));
    tbl.push_back(mk(1,1,1,1, 0,0,0,0, 0,38));
    tbl.push_back(mk(1,1,0,1, 7,8,8,8, 0,38));
    tbl.push_back(mk(1,1,0,1, 8,7,9,9, 0,38));
    tbl.push_back(mk(1,0,0,1, 8,7,9,9, 0,38));
    tbl.push_back(mk(1,1,0,1, 9,9,1,9, 0,38));
    tbl.push_back(mk(1,1,0,1, 9,9,9,9, 0,38));
    tbl.push_back(mk(1,0,0,1, 9,9,9,9, 1,26));
    tbl.push_back(mk(1,0,0,1, 9,9,9,9, 0,26));
    tbl.push_back(mk(2,1,0,1, 19,17,0,0, 0,0));
    tbl.push_back(mk(2,1,0,1, 24,18,0,0, 0,0));
    tbl.push_back(mk(2,1,0,1, 124,124,0,0, 0,0));
    tbl.push_back(mk(2,0,0,1, 124,124,0,0, 1,131));
    tbl.push_back(mk(2,0,0,1, 124,124,0,0, 0,131));

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t t = tbl[k];
      set_idle();
      ce[t.inst] = t.c; vl[t.inst] = t.v; fl[t.inst] = t.f;
      in_e[t.inst][0][0] = t.e0; in_e[t.inst][0][1] = t.e1;
      in_e[t.inst][0][2] = t.e2; in_e[t.inst][0][3] = t.e3;
      cycle($sformatf("vec%0d", k));
      check_val($sformatf("vec%0d en", k), int'(get_en(t.inst)), int'(t.xen));
      check_val($sformatf("vec%0d g0", k), get_out(t.inst, 0), t.xg0);
    end

    // Reset in the middle of a 3-beat fold on C.
    set_idle();
    in_e[2][0][0] = 0; in_e[2][0][1] = 0;
    vl[2] = 1; cycle("pre_rst0");
    cycle("pre_rst1");
    vl[2] = 0; cycle("pre_rst2");
    rst = 1'b0;
    #1;
    check_val("rst en_a", int'(en_a), 0);
    check_val("rst out_a nonzero bits", int'($countones(out_a)), 0);
    check_val("rst en_c", int'(en_c), 0);
    check_val("rst out_c", int'(out_c), 0);
    check_val("rst out_b", int'(out_b), 0);
    model_reset();
    check_all("in_rst");
    #1 rst = 1'b1;
    set_idle();
    vl[2] = 1;
    in_e[2][0][0] = (10 << 2) | 1; in_e[2][0][1] = 12 << 2;
    cycle("post_rst0");
    in_e[2][0][0] = (3 << 2) | 2;  in_e[2][0][1] = 10 << 2;
    cycle("post_rst1");
    in_e[2][0][0] = 20 << 2;       in_e[2][0][1] = (3 << 2) | 1;
    cycle("post_rst2");
    vl[2] = 0;
    cycle("post_rst3");
    check_val("post_rst en_c", int'(en_c), 1);
    check_val("post_rst g0", get_out(2, 0), 106);
    cycle("post_rst4");
    check_val("post_rst en_c drop", int'(en_c), 0);

    // Randomized traffic on all instances against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        ce[i] = ($urandom_range(0, 9) != 0);
        vl[i] = ($urandom_range(0, 3) != 0);
        fl[i] = ($urandom_range(0, 24) == 0);
        for (int g = 0; g < ng_p[i]; g++)
          for (int r = 0; r < rad_p[i]; r++)
            in_e[i][g][r] = (int'($urandom_range(0, 7)) << sw_p[i]) |
                            int'($urandom_range(0, (1 << sw_p[i]) - 1));
      end
      cycle($sformatf("rand%0d", n));
    end
    set_idle();
    for (int n = 0; n < 4; n++) cycle("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_min_reduce.md
DISP_MIN_REDUCE -- requirements
Module: disp_min_reduce

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 64: number of independent min-reduction groups.
REQ-002 SHALL have parameter RADIX, default 4: costs per group per beat; legal values are 2, 4 and 8. Define RW = log2(RADIX).
REQ-003 SHALL have parameter COST_W, default 5: cost field width, unsigned.
REQ-004 SHALL have parameter SUF_W, default 0: width of the index suffix carried in from the previous stage (0..8).
REQ-005 SHALL have parameter BEATS, default 1: input beats folded into one result (1..16). Define BW = clog2(BEATS), with BW = 0 when BEATS = 1.
REQ-006 SHALL use entry widths IW = COST_W+SUF_W and OW = COST_W+BW+RW+SUF_W.
REQ-007 SHALL have clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have clken, input, 1 bit: global clock enable; all state advances only when clken = 1.
REQ-010 SHALL have valid, input, 1 bit: cost_in carries a beat this cycle.
REQ-011 SHALL have flush, input, 1 bit: synchronous restart of beat folding.
REQ-012 SHALL have cost_in, input, NUM_GROUPS*RADIX*IW bits. Group g, entry r occupies bits [(g*RADIX+r)*IW +: IW]. Within an entry, cost is in the MSBs and the suffix in the LSBs.
REQ-013 SHALL have cost_out, output, NUM_GROUPS*OW bits. Group g occupies bits [g*OW +: OW], packed as {cost, beat_idx, radix_idx, suffix} from MSB to LSB.
REQ-014 SHALL have en, output, 1 bit: cost_out holds a new result.

Function
REQ-015 Stage 1 SHALL register, per group, the minimum entry over the RADIX costs, its radix index and its suffix; s1_valid captures valid. Updates occur on clken only.
REQ-016 Ties in stage 1 SHALL resolve to the lowest radix index.
REQ-017 Comparisons SHALL use the cost field only, as an unsigned compare. The suffix is carried unchanged.
REQ-018 Stage 2 SHALL keep a beat counter beat_cnt (BW bits) and a per-group accumulator.
REQ-019 On clken with s1_valid, when beat_cnt = 0, the accumulator SHALL load the stage-1 result with beat_idx = 0.
REQ-020 On clken with s1_valid, when beat_cnt > 0, the accumulator SHALL be replaced only if the stage-1 cost is strictly less than the stored cost, taking beat_idx = beat_cnt. Ties keep the earlier beat.
REQ-021 beat_cnt SHALL increment on each consumed s1_valid beat and wrap from BEATS-1 to 0.
REQ-022 When the consumed beat has beat_cnt = BEATS-1, cost_out SHALL load the final min (including that beat) and en SHALL be 1 on the next cycle. Otherwise en SHALL be 0 after that clken edge.
REQ-023 Latency SHALL be two clken edges from the last beat's valid to en = 1: edge 1 captures stage 1, edge 2 loads cost_out and en.
REQ-024 With BEATS = 1, every valid beat SHALL produce a result two clken edges later, one result per cycle at full throughput.
REQ-025 With clken = 0, all registers SHALL hold, including en and cost_out; valid is ignored that cycle.
REQ-026 cost_out SHALL hold its value between results.
REQ-027 flush with clken = 1 SHALL clear beat_cnt, s1_valid and en to 0. It SHALL discard any partial fold and the beat presented that cycle, and SHALL leave cost_out unchanged. flush has priority over valid.
REQ-028 Gaps in valid SHALL not advance beat_cnt or disturb the accumulator.

Reset
REQ-029 While rst = 0, en, s1_valid, beat_cnt, all stage-1 registers, accumulators and cost_out SHALL be 0, asynchronously.
REQ-030 On release of rst, the block SHALL accept a beat on the first clken cycle. A fold in progress at reset is lost with no partial result.

Verification
REQ-031 Defaults: group 0 costs {9,3,7,3}, valid for one cycle, clken = 1 -> two edges later en = 1 for one cycle and group 0 out = {cost 3, radix_idx 1}.
REQ-032 BEATS = 4, RADIX = 4: group 0 beat minima 6,2,2,5 -> en = 1 only after the 4th beat plus two edges, with out cost 2, beat_idx 1.
REQ-033 BEATS = 4: two beats, then flush, then four beats with minima 7,7,1,9 -> exactly one en pulse with cost 1, beat_idx 2; the pre-flush beats have no effect.
REQ-034 clken held at 0 for 3 cycles between valid and output -> en and cost_out frozen; result appears two clken-high edges after valid.
REQ-035 SUF_W = 2, RADIX = 2: entries {cost 4, suffix 3} and {cost 4, suffix 1} -> out cost 4, radix_idx 0, suffix 3.
REQ-036 rst asserted mid-fold with BEATS = 3 after 2 beats -> all outputs 0 at once; after release, 3 new beats give one correct result.
